// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one SRAM-like memory port between the instruction-fetch requester
// and the data (load/store) requester. Only one transaction is in flight at
// a time. The arbiter sequences the request / address-accept / data-return
// handshake and routes each response back to the requester that owns the
// transaction. An instruction response that is still outstanding when the
// pipeline flushes is dropped, but the memory-side handshake is still
// completed.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   i_inst_req/addr     : instruction read request (held until addr_ok)
//   i_inst_cancel       : flush pulse, drops an outstanding instruction response
//   o_inst_addr_ok      : instruction request accepted by memory
//   o_inst_data_ok      : instruction word valid on o_inst_rdata
//   i_data_req/wr/size/wstrb/addr/wdata : data request (held until addr_ok)
//   o_data_addr_ok      : data request accepted by memory
//   o_data_data_ok      : load data valid / store completed
//   o_mem_*             : shared port request, driven from latched fields
//   i_mem_addr_ok       : port accepted the request
//   i_mem_data_ok       : port returned data or write acknowledgement
//   i_mem_rdata         : returned data
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inst_req,
  input  logic [ADDR_W-1:0] i_inst_addr,
  input  logic              i_inst_cancel,
  output logic              o_inst_addr_ok,
  output logic              o_inst_data_ok,
  output logic [DATA_W-1:0] o_inst_rdata,
  input  logic              i_data_req,
  input  logic              i_data_wr,
  input  logic [1:0]        i_data_size,
  input  logic [3:0]        i_data_wstrb,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [DATA_W-1:0] i_data_wdata,
  output logic              o_data_addr_ok,
  output logic              o_data_data_ok,
  output logic [DATA_W-1:0] o_data_rdata,
  output logic              o_mem_req,
  output logic              o_mem_wr,
  output logic [1:0]        o_mem_size,
  output logic [3:0]        o_mem_wstrb,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_addr_ok,
  input  logic              i_mem_data_ok,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  state_t            r_state;
  state_t            w_nextState;
  owner_t            r_owner;
  owner_t            r_last;
  logic              r_cancelPend;
  logic              r_memWr;
  logic [1:0]        r_memSize;
  logic [3:0]        r_memWstrb;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              w_instElig;
  logic              w_grant;
  logic              w_grantData;

  // Read data is simply forwarded; it only means something alongside data_ok.
  assign o_inst_rdata = i_mem_rdata;
  assign o_data_rdata = i_mem_rdata;

  // The shared port always sees the latched fields, so they stay stable
  // while the slave stalls address acceptance.
  assign o_mem_wr    = r_memWr;
  assign o_mem_size  = r_memSize;
  assign o_mem_wstrb = r_memWstrb;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wdata = r_memWdata;

  // Next-state and handshake outputs. A flushed instruction request is not
  // eligible in IDLE. On a tie the requester that was not served last wins.
  always_comb begin
    w_nextState    = r_state;
    w_instElig     = i_inst_req & ~i_inst_cancel;
    w_grant        = 1'b0;
    w_grantData    = 1'b0;
    o_mem_req      = 1'b0;
    o_inst_addr_ok = 1'b0;
    o_data_addr_ok = 1'b0;
    o_inst_data_ok = 1'b0;
    o_data_data_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_instElig && i_data_req) begin
          w_grant     = 1'b1;
          w_grantData = (r_last == OWN_INST);
        end else if (w_instElig || i_data_req) begin
          w_grant     = 1'b1;
          w_grantData = i_data_req;
        end
        if (w_grant) w_nextState = S_REQ;
      end
      S_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_addr_ok) begin
          o_inst_addr_ok = (r_owner == OWN_INST);
          o_data_addr_ok = (r_owner == OWN_DATA);
          w_nextState    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_data_ok) begin
          // A flush in this very cycle also drops the response.
          o_inst_data_ok = (r_owner == OWN_INST) && !r_cancelPend && !i_inst_cancel;
          o_data_data_ok = (r_owner == OWN_DATA);
          w_nextState    = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // State, ownership, round-robin history, pending-cancel flag and the
  // latched request fields. Instruction grants present a plain word read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_INST;
      r_last       <= OWN_INST;
      r_cancelPend <= 1'b0;
      r_memWr      <= 1'b0;
      r_memSize    <= 2'd0;
      r_memWstrb   <= 4'd0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_grant) begin
        if (w_grantData) begin
          r_owner    <= OWN_DATA;
          r_memWr    <= i_data_wr;
          r_memSize  <= i_data_size;
          r_memWstrb <= i_data_wstrb;
          r_memAddr  <= i_data_addr;
          r_memWdata <= i_data_wdata;
        end else begin
          r_owner    <= OWN_INST;
          r_memWr    <= 1'b0;
          r_memSize  <= 2'd2;
          r_memWstrb <= 4'd0;
          r_memAddr  <= i_inst_addr;
          r_memWdata <= '0;
        end
      end
      if (r_state == S_WAIT && i_mem_data_ok) r_last <= r_owner;
      if (w_nextState == S_IDLE) begin
        r_cancelPend <= 1'b0;
      end else if (r_state != S_IDLE && r_owner == OWN_INST && i_inst_cancel) begin
        r_cancelPend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. A small slave model answers the
// shared port with programmable accept/return delays. Expected port
// requests and per-requester responses are queued when stimulus is issued;
// a monitor pops and compares them whenever the DUT accepts or responds.
module tb_mem_port_arbiter;

  typedef struct {
    logic        isData;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_inst_req, i_inst_cancel;
  logic [31:0] i_inst_addr;
  logic        o_inst_addr_ok, o_inst_data_ok;
  logic [31:0] o_inst_rdata;
  logic        i_data_req, i_data_wr;
  logic [1:0]  i_data_size;
  logic [3:0]  i_data_wstrb;
  logic [31:0] i_data_addr, i_data_wdata;
  logic        o_data_addr_ok, o_data_data_ok;
  logic [31:0] o_data_rdata;
  logic        o_mem_req, o_mem_wr;
  logic [1:0]  o_mem_size;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_addr_ok, i_mem_data_ok;
  logic [31:0] i_mem_rdata;

  req_t        expReqQ[$];
  logic [31:0] expInstQ[$];
  logic [31:0] expDataQ[$];
  logic [31:0] rdataQ[$];
  int          checks = 0;
  int          errors = 0;
  bit          slaveEn;
  int          addrDelay;
  int          dataDelay;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr), .i_inst_cancel(i_inst_cancel),
    .o_inst_addr_ok(o_inst_addr_ok), .o_inst_data_ok(o_inst_data_ok), .o_inst_rdata(o_inst_rdata),
    .i_data_req(i_data_req), .i_data_wr(i_data_wr), .i_data_size(i_data_size),
    .i_data_wstrb(i_data_wstrb), .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .o_data_addr_ok(o_data_addr_ok), .o_data_data_ok(o_data_data_ok), .o_data_rdata(o_data_rdata),
    .o_mem_req(o_mem_req), .o_mem_wr(o_mem_wr), .o_mem_size(o_mem_size),
    .o_mem_wstrb(o_mem_wstrb), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_addr_ok(i_mem_addr_ok), .i_mem_data_ok(i_mem_data_ok), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  function automatic req_t mkReq(input logic isData, input logic wr, input logic [1:0] size,
                                 input logic [3:0] wstrb, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.isData = isData; r.wr = wr; r.size = size; r.wstrb = wstrb; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one request and holds it until the owner's addr_ok is seen.
  // Called and returns just after a rising edge.
  task automatic applyStimulus(input req_t r, input bit pushGrant);
    int waitCycles;
    waitCycles = 0;
    if (pushGrant) expReqQ.push_back(r);
    if (r.isData) begin
      i_data_wr = r.wr; i_data_size = r.size; i_data_wstrb = r.wstrb;
      i_data_addr = r.addr; i_data_wdata = r.wdata; i_data_req = 1'b1;
    end else begin
      i_inst_addr = r.addr; i_inst_req = 1'b1;
    end
    forever begin
      @(negedge clk);
      if (r.isData ? o_data_addr_ok : o_inst_addr_ok) break;
      waitCycles++;
      if (waitCycles > 50) begin
        checkOutput("addrOkTimeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (r.isData) i_data_req = 1'b0;
    else i_inst_req = 1'b0;
  endtask

  // Slave model: accepts after addrDelay REQ cycles, returns after
  // dataDelay further cycles, with data taken from rdataQ.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!slaveEn) begin
        phase = 0;
        cnt = 0;
      end else begin
        i_mem_addr_ok = 1'b0;
        i_mem_data_ok = 1'b0;
        if (phase == 0) begin
          if (o_mem_req) begin
            if (cnt >= addrDelay) begin
              i_mem_addr_ok = 1'b1;
              phase = 1;
              cnt = 0;
            end else cnt++;
          end
        end else begin
          if (cnt >= dataDelay) begin
            i_mem_data_ok = 1'b1;
            i_mem_rdata = (rdataQ.size() > 0) ? rdataQ.pop_front() : 32'h0;
            phase = 0;
            cnt = 0;
          end else cnt++;
        end
      end
    end
  end

  // Monitor: compares accepted requests and responses against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (o_mem_req && i_mem_addr_ok) begin
        if (expReqQ.size() == 0) checkOutput("unexpectedAccept", 1, 0);
        else begin
          req_t e;
          e = expReqQ.pop_front();
          checkOutput("memAddr", o_mem_addr, e.addr);
          checkOutput("memWr", 32'(o_mem_wr), 32'(e.wr));
          checkOutput("memSize", 32'(o_mem_size), 32'(e.size));
          checkOutput("memWstrb", 32'(o_mem_wstrb), 32'(e.wstrb));
          checkOutput("memWdata", o_mem_wdata, e.wdata);
          checkOutput("instAddrOk", 32'(o_inst_addr_ok), 32'(!e.isData));
          checkOutput("dataAddrOk", 32'(o_data_addr_ok), 32'(e.isData));
        end
      end else if (o_inst_addr_ok || o_data_addr_ok) begin
        checkOutput("spuriousAddrOk", 1, 0);
      end
      if (o_inst_data_ok) begin
        if (expInstQ.size() == 0) checkOutput("unexpectedInstDataOk", 1, 0);
        else checkOutput("instRdata", o_inst_rdata, expInstQ.pop_front());
      end
      if (o_data_data_ok) begin
        if (expDataQ.size() == 0) checkOutput("unexpectedDataDataOk", 1, 0);
        else checkOutput("dataRdata", o_data_rdata, expDataQ.pop_front());
      end
      if (o_inst_data_ok && o_data_data_ok) checkOutput("bothDataOk", 1, 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    i_inst_req = 0; i_inst_cancel = 0; i_inst_addr = 0;
    i_data_req = 0; i_data_wr = 0; i_data_size = 0; i_data_wstrb = 0;
    i_data_addr = 0; i_data_wdata = 0;
    i_mem_addr_ok = 0; i_mem_data_ok = 0; i_mem_rdata = 0;
    slaveEn = 1; addrDelay = 0; dataDelay = 0;
    rst_n = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstMemReq", 32'(o_mem_req), 0);
    checkOutput("rstMemAddr", o_mem_addr, 0);
    checkOutput("rstMemSize", 32'(o_mem_size), 0);
    checkOutput("rstAddrOk", 32'({o_inst_addr_ok, o_data_addr_ok}), 0);
    checkOutput("rstDataOk", 32'({o_inst_data_ok, o_data_data_ok}), 0);
    tick(1);
    rst_n = 1;

    // Both requesters continuously from reset: DATA, INST, DATA, INST
    $display("[TB] round-robin");
    expReqQ.push_back(mkReq(1, 0, 2'd2, 4'h0, 32'h0000_4000, 32'hCAFE_0000));
    expReqQ.push_back(mkReq(0, 0, 2'd2, 4'h0, 32'h0000_8000, 32'h0));
    expReqQ.push_back(mkReq(1, 0, 2'd2, 4'h0, 32'h0000_4004, 32'hCAFE_0000));
    expReqQ.push_back(mkReq(0, 0, 2'd2, 4'h0, 32'h0000_8004, 32'h0));
    rdataQ.push_back(32'h1111_0000); rdataQ.push_back(32'h2222_0000);
    rdataQ.push_back(32'h3333_0000); rdataQ.push_back(32'h4444_0000);
    expDataQ.push_back(32'h1111_0000); expDataQ.push_back(32'h3333_0000);
    expInstQ.push_back(32'h2222_0000); expInstQ.push_back(32'h4444_0000);
    fork
      begin
        applyStimulus(mkReq(1, 0, 2'd2, 4'h0, 32'h0000_4000, 32'hCAFE_0000), 0);
        applyStimulus(mkReq(1, 0, 2'd2, 4'h0, 32'h0000_4004, 32'hCAFE_0000), 0);
      end
      begin
        applyStimulus(mkReq(0, 0, 2'd2, 4'h0, 32'h0000_8000, 32'h0), 0);
        applyStimulus(mkReq(0, 0, 2'd2, 4'h0, 32'h0000_8004, 32'h0), 0);
      end
    join
    tick(5);

    // Single load, data returned two cycles after accept
    $display("[TB] single load");
    dataDelay = 1;
    rdataQ.push_back(32'hDEAD_BEEF);
    expDataQ.push_back(32'hDEAD_BEEF);
    fork
      applyStimulus(mkReq(1, 0, 2'd2, 4'h0, 32'h0000_1000, 32'h0), 1);
      begin
        @(negedge clk);
        checkOutput("loadCyc0MemReq", 32'(o_mem_req), 0);
        @(negedge clk);
        checkOutput("loadCyc1MemReq", 32'(o_mem_req), 1);
        checkOutput("loadCyc1DataAddrOk", 32'(o_data_addr_ok), 1);
        checkOutput("loadCyc1InstAddrOk", 32'(o_inst_addr_ok), 0);
        @(negedge clk);
        checkOutput("loadCyc2DataOk", 32'(o_data_data_ok), 0);
        @(negedge clk);
        checkOutput("loadCyc3DataOk", 32'(o_data_data_ok), 1);
        checkOutput("loadCyc3Rdata", o_data_rdata, 32'hDEAD_BEEF);
        checkOutput("loadCyc3InstDataOk", 32'(o_inst_data_ok), 0);
      end
    join
    tick(2);
    dataDelay = 0;

    // Store with address accept delayed by three cycles
    $display("[TB] delayed store");
    addrDelay = 3;
    rdataQ.push_back(32'h0);
    expDataQ.push_back(32'h0);
    fork
      applyStimulus(mkReq(1, 1, 2'd1, 4'b0011, 32'h0000_3000, 32'h1234_5678), 1);
      begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checkOutput("storeMemReq", 32'(o_mem_req), 1);
          checkOutput("storeMemAddr", o_mem_addr, 32'h0000_3000);
          checkOutput("storeMemWdata", o_mem_wdata, 32'h1234_5678);
          checkOutput("storeMemWstrb", 32'(o_mem_wstrb), 32'h3);
          checkOutput("storeMemWr", 32'(o_mem_wr), 1);
          checkOutput("storeAddrOkPulse", 32'(o_data_addr_ok), (k == 3) ? 1 : 0);
        end
      end
    join
    tick(3);
    addrDelay = 0;

    // Flush one cycle after the instruction is accepted
    $display("[TB] cancel in flight");
    dataDelay = 2;
    rdataQ.push_back(32'h0BAD_F00D);
    applyStimulus(mkReq(0, 0, 2'd2, 4'h0, 32'hBFC0_0000, 32'h0), 1);
    i_inst_cancel = 1;
    tick(1);
    i_inst_cancel = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i_mem_data_ok) begin
        seen = 1;
        checkOutput("cancelInstDataOk", 32'(o_inst_data_ok), 0);
        break;
      end
    end
    checkOutput("cancelMemDataSeen", 32'(seen), 1);
    tick(1);
    dataDelay = 0;
    rdataQ.push_back(32'h3C1A_0001);
    expInstQ.push_back(32'h3C1A_0001);
    applyStimulus(mkReq(0, 0, 2'd2, 4'h0, 32'hBFC0_0380, 32'h0), 1);
    tick(3);

    // Flush in the same cycle as the instruction response
    $display("[TB] cancel with data_ok");
    rdataQ.push_back(32'h5555_AAAA);
    applyStimulus(mkReq(0, 0, 2'd2, 4'h0, 32'hBFC0_0100, 32'h0), 1);
    i_inst_cancel = 1;
    @(negedge clk);
    checkOutput("simulMemDataOk", 32'(i_mem_data_ok), 1);
    checkOutput("simulInstDataOk", 32'(o_inst_data_ok), 0);
    tick(1);
    i_inst_cancel = 0;
    tick(1);

    // Flush has no effect on a data transaction
    rdataQ.push_back(32'h600D_D00D);
    expDataQ.push_back(32'h600D_D00D);
    applyStimulus(mkReq(1, 0, 2'd2, 4'hF, 32'h0000_5000, 32'h0), 1);
    i_inst_cancel = 1;
    tick(1);
    i_inst_cancel = 0;
    tick(2);

    // Cancel together with inst_req in IDLE blocks the grant for that cycle
    $display("[TB] cancel in idle");
    i_inst_addr = 32'h0000_9000;
    i_inst_req = 1;
    i_inst_cancel = 1;
    tick(1);
    i_inst_cancel = 0;
    checkOutput("idleCancelNoGrant", 32'(o_mem_req), 0);
    rdataQ.push_back(32'h0000_0077);
    expInstQ.push_back(32'h0000_0077);
    fork
      applyStimulus(mkReq(0, 0, 2'd2, 4'h0, 32'h0000_9000, 32'h0), 1);
      begin
        @(negedge clk);
        checkOutput("idleCancelStillIdle", 32'(o_mem_req), 0);
        @(negedge clk);
        checkOutput("idleCancelGranted", 32'(o_mem_req), 1);
      end
    join
    tick(3);

    // Reset while waiting for data; a late data_ok must be ignored
    $display("[TB] reset in wait");
    @(negedge clk);
    slaveEn = 0;
    i_mem_addr_ok = 0;
    i_mem_data_ok = 0;
    tick(1);
    expReqQ.push_back(mkReq(1, 0, 2'd2, 4'hF, 32'h0000_2000, 32'h0000_0055));
    i_data_wr = 0; i_data_size = 2'd2; i_data_wstrb = 4'hF;
    i_data_addr = 32'h0000_2000; i_data_wdata = 32'h0000_0055; i_data_req = 1;
    tick(1);
    i_data_req = 0;
    i_mem_addr_ok = 1;
    @(negedge clk);
    checkOutput("rstWaitAccepted", 32'(o_data_addr_ok), 1);
    tick(1);
    i_mem_addr_ok = 0;
    rst_n = 0;
    tick(1);
    rst_n = 1;
    @(negedge clk);
    checkOutput("rstWaitMemReq", 32'(o_mem_req), 0);
    checkOutput("rstWaitMemAddr", o_mem_addr, 0);
    tick(1);
    i_mem_data_ok = 1;
    i_mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    checkOutput("rstWaitDataOk", 32'(o_data_data_ok), 0);
    checkOutput("rstWaitInstOk", 32'(o_inst_data_ok), 0);
    tick(1);
    i_mem_data_ok = 0;
    tick(2);

    checkOutput("reqQueueEmpty", 32'(expReqQ.size()), 0);
    checkOutput("instQueueEmpty", 32'(expInstQ.size()), 0);
    checkOutput("dataQueueEmpty", 32'(expDataQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single SRAM-like memory port between the instruction-fetch requester (driven from the fetch stage's `inst_sram_addr`) and the data-access requester (MEM stage loads/stores). It grants one transaction at a time, sequences the request/address-accept/data-return handshake on the shared port, and routes each response back to its owner. It also discards an in-flight instruction response when the pipeline flushes on an exception or interrupt.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, synchronous, active-low.
- `inst_req  in  1`: instruction read request; held until `inst_addr_ok`.
- `inst_addr  in  ADDR_W`: instruction fetch address.
- `inst_cancel  in  1`: flush pulse; drops any outstanding instruction response.
- `inst_addr_ok  out  1`: instruction request accepted by memory.
- `inst_data_ok  out  1`: instruction data valid.
- `inst_rdata  out  DATA_W`: instruction word.
- `data_req  in  1`: data request; held until `data_addr_ok`.
- `data_wr  in  1`: 1 = store, 0 = load.
- `data_size  in  2`: access size; 0 = byte, 1 = half, 2 = word.
- `data_wstrb  in  4`: byte enables for stores.
- `data_addr  in  ADDR_W`: data address.
- `data_wdata  in  DATA_W`: store data.
- `data_addr_ok  out  1`: data request accepted.
- `data_data_ok  out  1`: load data valid, or store completed.
- `data_rdata  out  DATA_W`: load data.
- `mem_req  out  1`: request to the shared port.
- `mem_wr`, `mem_size`, `mem_wstrb`, `mem_addr`, `mem_wdata`  out  1/2/4/ADDR_W/DATA_W: latched request fields.
- `mem_addr_ok  in  1`: port accepted the request.
- `mem_data_ok  in  1`: port returned data or write acknowledgement.
- `mem_rdata  in  DATA_W`: returned data.

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: `owner` (INST/DATA), `last` (INST/DATA), `cancel_pend`.
- IDLE:
  - Arbitrate between `inst_req` (masked by `inst_cancel`) and `data_req`.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the requester that is not `last` (round-robin).
  - On grant: latch the `mem_*` fields (instruction grants use `wr=0`, `size=2`, `wstrb=0`, `wdata=0`), set `owner`, go to REQ.
  - If nothing is granted, stay in IDLE.
- REQ:
  - `mem_req=1`, driven from the latched fields.
  - When `mem_addr_ok=1`: pulse the owner's `*_addr_ok` in the same cycle (combinational), go to WAIT.
  - Otherwise hold all fields stable.
- WAIT:
  - `mem_req=0`.
  - When `mem_data_ok=1`: pulse the owner's `*_data_ok` in the same cycle with `*_rdata = mem_rdata`, set `last = owner`, go to IDLE.
  - For owner INST, `inst_data_ok` is suppressed if `cancel_pend` is set or `inst_cancel=1` that cycle.
- Cancel rules:
  - `inst_cancel` in REQ or WAIT with owner INST sets `cancel_pend`. The memory-side handshake still completes normally; `inst_addr_ok` is still pulsed.
  - `cancel_pend` clears on entering IDLE.
  - `inst_cancel` with owner DATA has no effect.
- `*_rdata` outputs equal `mem_rdata` unconditionally; they are valid only alongside their `*_data_ok`.
- The non-owner's `*_addr_ok` and `*_data_ok` are always 0.
- Only one transaction is outstanding at a time; no pipelining of requests.

## Timing
- Reset state:
  - state = IDLE, `owner` = INST, `last` = INST, so data wins the first tie.
  - `cancel_pend` = 0.
  - `mem_req`, all `*_addr_ok`, and all `*_data_ok` = 0.
  - Latched `mem_*` fields = 0.
- Reset mid-transaction returns to IDLE next cycle. Any later `mem_data_ok` is ignored, since the memory port is reset on the same `rst_n`.
- Latency with a zero-wait slave:
  - Request seen in cycle 0 (IDLE).
  - Cycle 1: `mem_req` and `addr_ok`.
  - Cycle 2 at the earliest: `data_ok`.
  - Cycle 3: back in IDLE and able to grant, so the next `mem_req` is at cycle 4.
  - Minimum issue interval is 3 cycles.
- `mem_addr_ok` is ignored outside REQ; `mem_data_ok` is ignored outside WAIT.
- Requester inputs are sampled only in IDLE; changes after grant do not affect the latched transaction.
- Simultaneous `inst_cancel` and `mem_data_ok` in WAIT: response dropped, FSM still returns to IDLE.

## Test plan
- Single load, `data_addr=0x1000`, slave returns `0xDEADBEEF` after 2 cycles:
  - `mem_req` at cycle 1 with `mem_wr=0`, `mem_size=2`.
  - `data_addr_ok` pulses at cycle 1.
  - `data_data_ok` pulses with `data_rdata=0xDEADBEEF` at cycle 3.
  - `inst_*_ok` stay 0.
- `inst_req` and `data_req` both asserted continuously from reset:
  - Grant order is DATA, INST, DATA, INST.
  - `mem_addr` alternates between the two addresses.
- Instruction fetch `0xBFC00000` with `inst_cancel` pulsed one cycle after `inst_addr_ok`:
  - `mem_data_ok` arrives, but `inst_data_ok` stays 0.
  - FSM returns to IDLE and a following `inst_req 0xBFC00380` is granted and returns normally.
- Store with `data_wstrb=4'b0011`, `data_wdata=0x12345678`, slave delays `mem_addr_ok` by 3 cycles:
  - `mem_req` and all `mem_*` fields stay stable through the wait.
  - `data_addr_ok` pulses only in the accept cycle.
- `rst_n` asserted while in WAIT:
  - Next cycle: state IDLE, `mem_req=0`.
  - A `mem_data_ok` pulse injected afterwards produces no `*_data_ok`.
- `inst_cancel` and `inst_req` high together in IDLE with `data_req=0`:
  - No grant, `mem_req` stays 0.
  - Next cycle, with cancel low, the instruction request is granted.
